// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: byte-enabled write port, registered flagged read port.
// Define RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module ram_dual_port #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int ADD_SIZE  = 10,
    parameter int RDW_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_select,
    input  logic                   wr_en,
    input  logic [MEM_WIDTH/8-1:0] wr_be,
    input  logic [ADD_SIZE-1:0]    addr_wr,
    input  logic [MEM_WIDTH-1:0]   din,
    input  logic                   rd_en,
    input  logic [ADD_SIZE-1:0]    addr_rd,
    output logic [MEM_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic                   rd_err
);

    localparam int unsigned NB = MEM_WIDTH / 8;
    localparam logic [ADD_SIZE:0] DEPTH_L = (ADD_SIZE + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic                 wr_fire, rd_fire, rd_in_range;
    logic [MEM_WIDTH-1:0] rd_word;
    logic [MEM_WIDTH-1:0] dout_d, dout_q;
    logic                 valid_d, valid_q;
    logic                 err_d, err_q;

    // Writes are gated by reset so an access held during reset cannot land.
    assign wr_fire     = rst & blk_select & wr_en & ({1'b0, addr_wr} < DEPTH_L);
    assign rd_fire     = blk_select & rd_en;
    assign rd_in_range = {1'b0, addr_rd} < DEPTH_L;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[addr_wr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // Write-first mode bypasses the enabled din bytes over the stored word.
    always_comb begin
        rd_word = mem[addr_rd];
        if (RDW_MODE == 1 && wr_fire && addr_wr == addr_rd) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = rd_fire;
        err_d   = rd_fire & ~rd_in_range;
        if (rd_fire) dout_d = rd_in_range ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [MEM_WIDTH-1:0] dout2_d, dout2_q;
    logic                 valid2_d, valid2_q;
    logic                 err2_d, err2_q;

    always_comb begin
        dout2_d  = valid_q ? dout_q : dout2_q;
        valid2_d = valid_q;
        err2_d   = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout2_q  <= '0;
            valid2_q <= 1'b0;
            err2_q   <= 1'b0;
        end else begin
            dout2_q  <= dout2_d;
            valid2_q <= valid2_d;
            err2_q   <= err2_d;
        end
    end

    assign dout       = dout2_q;
    assign dout_valid = valid2_q;
    assign rd_err     = err2_q;
`else
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign rd_err     = err_q;
`endif

endmodule

// File: tb/tb_ram_dual_port.sv
// Directed self-checking bench for ram_dual_port: one read-first and one write-first
// instance (MEM_DEPTH=1000) share stimulus; RAM_OUT_REG_EN selects expected latency.
module tb_ram_dual_port;

`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        blk_select = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_be = 2'b00;
    logic [9:0]  addr_wr = '0;
    logic [15:0] din = '0;
    logic        rd_en = 1'b0;
    logic [9:0]  addr_rd = '0;
    logic [15:0] dout0, dout1;
    logic        valid0, valid1, err0, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dual_port #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADD_SIZE(10), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .blk_select(blk_select), .wr_en(wr_en), .wr_be(wr_be),
        .addr_wr(addr_wr), .din(din), .rd_en(rd_en), .addr_rd(addr_rd),
        .dout(dout0), .dout_valid(valid0), .rd_err(err0)
    );

    ram_dual_port #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADD_SIZE(10), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .blk_select(blk_select), .wr_en(wr_en), .wr_be(wr_be),
        .addr_wr(addr_wr), .din(din), .rd_en(rd_en), .addr_rd(addr_rd),
        .dout(dout1), .dout_valid(valid1), .rd_err(err1)
    );

    task automatic idle();
        blk_select = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wr_be      = 2'b00;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        wr_en = 1'b1; addr_wr = a; din = d; wr_be = be;
        @(posedge clk); #1;
        idle();
    endtask

    // Issues one read and returns #1 after the edge where its result is visible.
    task automatic do_read(input logic [9:0] a);
        @(negedge clk);
        rd_en = 1'b1; addr_rd = a;
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++; if (dout0 !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want %h", dout0, 16'h0000); end
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want %b", valid0, 1'b0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want %b", err0, 1'b0); end
        checks++; if (dout1 !== 16'h0000) begin errors++; $display("FAIL reset_dout1 got %h want %h", dout1, 16'h0000); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_preload_read();
        do_read(10'h005);
        checks++; if (dout0 !== 16'h0005) begin errors++; $display("FAIL preload_dout got %h want %h", dout0, 16'h0005); end
        checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL preload_valid got %b want %b", valid0, 1'b1); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL preload_err got %b want %b", err0, 1'b0); end
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL preload_valid1 got %b want %b", valid1, 1'b1); end
        @(posedge clk); #1;
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL preload_pulse got %b want %b", valid0, 1'b0); end
        checks++; if (dout0 !== 16'h0005) begin errors++; $display("FAIL preload_hold got %h want %h", dout0, 16'h0005); end
    endtask

    task automatic test_byte_enable();
        do_write(10'h010, 16'hABCD, 2'b01);
        do_write(10'h011, 16'h12FF, 2'b10);
        do_write(10'h012, 16'hFFFF, 2'b00);
        do_read(10'h010);
        checks++; if (dout0 !== 16'h00CD) begin errors++; $display("FAIL be_low got %h want %h", dout0, 16'h00CD); end
        do_read(10'h011);
        checks++; if (dout0 !== 16'h1211) begin errors++; $display("FAIL be_high got %h want %h", dout0, 16'h1211); end
        do_read(10'h012);
        checks++; if (dout0 !== 16'h0012) begin errors++; $display("FAIL be_none got %h want %h", dout0, 16'h0012); end
    endtask

    task automatic test_rdw();
        @(negedge clk);
        wr_en = 1'b1; addr_wr = 10'h020; din = 16'h1234; wr_be = 2'b11;
        rd_en = 1'b1; addr_rd = 10'h020;
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        checks++; if (dout0 !== 16'h0020) begin errors++; $display("FAIL rdw_read_first got %h want %h", dout0, 16'h0020); end
        checks++; if (dout1 !== 16'h1234) begin errors++; $display("FAIL rdw_write_first got %h want %h", dout1, 16'h1234); end
        @(negedge clk);
        wr_en = 1'b1; addr_wr = 10'h021; din = 16'hABCD; wr_be = 2'b01;
        rd_en = 1'b1; addr_rd = 10'h021;
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        checks++; if (dout0 !== 16'h0021) begin errors++; $display("FAIL rdw_part_read_first got %h want %h", dout0, 16'h0021); end
        checks++; if (dout1 !== 16'h00CD) begin errors++; $display("FAIL rdw_part_write_first got %h want %h", dout1, 16'h00CD); end
        do_read(10'h020);
        checks++; if (dout0 !== 16'h1234) begin errors++; $display("FAIL rdw_after0 got %h want %h", dout0, 16'h1234); end
        checks++; if (dout1 !== 16'h1234) begin errors++; $display("FAIL rdw_after1 got %h want %h", dout1, 16'h1234); end
    endtask

    task automatic test_diff_addr();
        @(negedge clk);
        wr_en = 1'b1; addr_wr = 10'h040; din = 16'h5555; wr_be = 2'b11;
        rd_en = 1'b1; addr_rd = 10'h041;
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        checks++; if (dout1 !== 16'h0041) begin errors++; $display("FAIL diff_read got %h want %h", dout1, 16'h0041); end
        do_read(10'h040);
        checks++; if (dout0 !== 16'h5555) begin errors++; $display("FAIL diff_write got %h want %h", dout0, 16'h5555); end
    endtask

    task automatic test_out_of_range();
        do_read(10'h3F0);
        checks++; if (dout0 !== 16'h0000) begin errors++; $display("FAIL oor_dout got %h want %h", dout0, 16'h0000); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oor_err got %b want %b", err0, 1'b1); end
        checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL oor_valid got %b want %b", valid0, 1'b1); end
        do_write(10'h3F0, 16'hFFFF, 2'b11);
        do_read(10'h3F0);
        checks++; if (dout0 !== 16'h0000) begin errors++; $display("FAIL oor_wr_dout got %h want %h", dout0, 16'h0000); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want %b", err0, 1'b1); end
        do_read(10'h1F0);
        checks++; if (dout0 !== 16'h01F0) begin errors++; $display("FAIL oor_alias got %h want %h", dout0, 16'h01F0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oor_alias_err got %b want %b", err0, 1'b0); end
        do_read(10'h3E7);
        checks++; if (dout0 !== 16'h03E7) begin errors++; $display("FAIL oor_last got %h want %h", dout0, 16'h03E7); end
    endtask

    task automatic test_blk_select();
        do_read(10'h007);
        @(negedge clk);
        blk_select = 1'b0;
        wr_en = 1'b1; addr_wr = 10'h050; din = 16'hDEAD; wr_be = 2'b11;
        rd_en = 1'b1; addr_rd = 10'h050;
        @(posedge clk); #1;
        idle();
        for (int c = 0; c < 2; c++) begin
            checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL blk_valid got %b want %b", valid0, 1'b0); end
            checks++; if (dout0 !== 16'h0007) begin errors++; $display("FAIL blk_hold got %h want %h", dout0, 16'h0007); end
            @(posedge clk); #1;
        end
        do_read(10'h050);
        checks++; if (dout0 !== 16'h0050) begin errors++; $display("FAIL blk_nowrite got %h want %h", dout0, 16'h0050); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) begin rd_en = 1'b1; addr_rd = 10'(10'h060 + c); end
            else rd_en = 1'b0;
            @(posedge clk); #1;
            if (c - (LAT - 1) >= 0 && c - (LAT - 1) < 3) begin
                checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b want %b", c, valid0, 1'b1); end
                checks++; if (dout0 !== 16'(16'h0060 + c - (LAT - 1))) begin errors++; $display("FAIL b2b_dout%0d got %h want %h", c, dout0, 16'(16'h0060 + c - (LAT - 1))); end
            end else if (c - (LAT - 1) == 3) begin
                checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want %b", valid0, 1'b0); end
            end
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        rd_en = 1'b1; addr_rd = 10'h00A;
        @(posedge clk); #2;
        rst = 1'b0;
        idle();
        wr_en = 1'b1; addr_wr = 10'h005; din = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; addr_rd = 10'h006;
        #1;
        checks++; if (dout0 !== 16'h0000) begin errors++; $display("FAIL rst_async_dout got %h want %h", dout0, 16'h0000); end
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want %b", valid0, 1'b0); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_no_pulse%0d got %b want %b", c, valid0, 1'b0); end
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_release%0d got %b want %b", c, valid0, 1'b0); end
        end
        do_read(10'h005);
        checks++; if (dout0 !== 16'h0005) begin errors++; $display("FAIL rst_mem_intact got %h want %h", dout0, 16'h0005); end
    endtask

    initial begin
        for (int i = 0; i < 1000; i++) begin
            dut0.mem[i] = 16'(i);
            dut1.mem[i] = 16'(i);
        end
        test_reset();
        test_preload_read();
        test_byte_enable();
        test_rdw();
        test_diff_addr();
        test_out_of_range();
        test_blk_select();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d want %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_dual_port.md
# ram_dual_port

Parametrised simple dual-port RAM with independent write and read ports, per-byte write enables, selectable read-during-write behaviour and a registered, flagged read output. It is the next-generation storage block for the lab datapaths: one write and one read per cycle, usable as a register file, line buffer or FIFO backing store. Memory contents are not cleared by reset, so simulation preload through the `mem` array remains valid.

## Interface

Parameters:
- `MEM_WIDTH`, 16, word width in bits; must be a multiple of 8.
- `MEM_DEPTH`, 1024, number of words; 2 ≤ `MEM_DEPTH` ≤ 2^`ADD_SIZE`.
- `ADD_SIZE`, 10, address width in bits.
- `RDW_MODE`, 0, read-during-write at the same address: 0 = read-first (old word), 1 = write-first (new word).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `blk_select`  in  1  block enable; when 0, both ports are idle.
- `wr_en`  in  1  write request.
- `wr_be`  in  MEM_WIDTH/8  byte enables; bit i covers `din[8i+7:8i]`.
- `addr_wr`  in  ADD_SIZE  write address.
- `din`  in  MEM_WIDTH  write data.
- `rd_en`  in  1  read request.
- `addr_rd`  in  ADD_SIZE  read address.
- `dout`  out  MEM_WIDTH  read data.
- `dout_valid`  out  1  one-cycle pulse marking new `dout`.
- `rd_err`  out  1  pulses with `dout_valid` when the read address is ≥ `MEM_DEPTH`.

## Operation

- Storage is `reg [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1]`; the array name `mem` is fixed.
- Write: on a rising edge with `blk_select & wr_en` and `addr_wr < MEM_DEPTH`:
  - For each i with `wr_be[i]=1`, `mem[addr_wr]` byte i ← `din` byte i.
  - Bytes with `wr_be[i]=0` are unchanged.
  - `wr_be = 0` performs no write.
- Out-of-range write (`addr_wr ≥ MEM_DEPTH`): silently dropped; no flag.
- Read: on a rising edge with `blk_select & rd_en`, the read is issued.
  - In range: `dout` ← `mem[addr_rd]`, `rd_err` ← 0.
  - Out of range: `dout` ← 0, `rd_err` ← 1.
  - In both cases `dout_valid` ← 1.
- No read issued: `dout` holds its last value; `dout_valid` and `rd_err` ← 0.
- Simultaneous read and write, different addresses: both complete independently in the same cycle.
- Simultaneous read and write, same in-range address:
  - `RDW_MODE=0`: `dout` = the word before the write.
  - `RDW_MODE=1`: `dout` = the merged word (enabled bytes from `din`, other bytes from the old word). Implement as a bypass mux, not as a second array read.
- Reset (`rst=0`), asynchronous:
  - `dout`=0, `dout_valid`=0, `rd_err`=0; the read pipeline is flushed.
  - `mem` is untouched.
  - While `rst=0`, writes and reads are blocked.
  - A read in flight when reset asserts is discarded; it never produces a `dout_valid`.

## Timing

- Write latency is 1 cycle: data written at edge N is readable by a read issued at edge N+1, and at edge N itself when `RDW_MODE=1`.
- Read latency, base build: a read issued at edge N has `dout`, `dout_valid` and `rd_err` valid after edge N, for one cycle.
- Read latency with `RAM_OUT_REG_EN`: outputs are valid after edge N+1.
- Throughput is one read and one write per cycle with no stalls.
- Back-to-back reads produce consecutive `dout_valid` pulses in issue order.
- Reset deassertion is synchronised by the user. The first edge after `rst` rises may issue accesses.

## Configuration

- `RAM_OUT_REG_EN` defined: adds a second output register stage after the array read.
  - `dout`, `dout_valid` and `rd_err` are delayed by one extra cycle (latency 2).
  - Read-during-write resolution is made at issue time (edge N), not at output time.
  - The extra stage resets to 0 like the first.
- `RAM_OUT_REG_EN` undefined: single output register (latency 1).

## Test plan

- Preload `mem` with `mem[i]=i`; after reset, read addr 0x005 -> `dout`=0x0005 and `dout_valid`=1 for one cycle (or one cycle later with `RAM_OUT_REG_EN`); `rd_err`=0.
- Write 0xABCD to 0x010 with `wr_be`=2'b01, then read 0x010 -> `dout`=0x00CD (old high byte 0x00 kept).
- Same-cycle write 0x1234, `wr_be`=2'b11, and read, both at 0x020 (old word 0x0020) -> `dout`=0x0020 with `RDW_MODE=0`, 0x1234 with `RDW_MODE=1`.
- `MEM_DEPTH`=1000: read 0x3F0 -> `dout`=0, `rd_err`=1, `dout_valid`=1; write 0x3F0 then read 0x3F0 -> still 0 and `rd_err`=1; no in-range word changes.
- `blk_select`=0 with `wr_en`=`rd_en`=1 -> no `dout_valid`, `dout` holds, `mem` unchanged.
- Assert `rst`=0 mid-clock-cycle right after a read issue -> `dout`=0, `dout_valid`=0 immediately, with no delayed pulse; preloaded contents are intact after release.
